// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// FSM encodings, the FIFO entry layout and a word-alignment helper.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// DEPTH x 64 synchronous FIFO of {pc, instr} with a registered head.
// flush wins over push; the head register holds its last value while empty.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] remain;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty;
    assign rd_next = rd_ptr + AW'(pop_ok);
    assign remain  = count_q - CW'(pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head tracks the entry at rd_next; a push into an empty queue bypasses the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            head    <= '{pc: 32'h0, instr: INSTR_NOP};
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_next;
            wr_ptr  <= wr_ptr + AW'(push_ok);
            count_q <= remain + CW'(push_ok);
            if (remain != '0) begin
                head <= mem[rd_next];
            end else if (push_ok) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: fetch PC, single-outstanding imem request FSM,
// and redirect handling that kills wrong-path words.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    localparam int         CW       = $clog2(DEPTH) + 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_b_taken,
    input  logic [31:0] i_b_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready,
    output logic        o_misaligned,
    output logic [1:0]  o_fsm_state
);

    // Handshakes: imem request is held with a stable address until i_imem_gnt
    // (only a redirect may retarget it); one response per grant, in order;
    // decode takes the head on the cycle o_instr_valid && i_instr_ready.

    fetch_state_e  state;
    fetch_state_e  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic          misaligned_q;

    logic          fifo_push;
    logic          fifo_pop_ok;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_after;
    logic          room_after;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;

    assign fifo_push   = (state == FETCH_WAIT) && i_imem_rvalid && !i_b_taken && !fifo_full;
    assign fifo_pop_ok = i_instr_ready && !fifo_empty;
    assign count_after = fifo_count + CW'(fifo_push) - CW'(fifo_pop_ok);
    assign room_after  = (count_after < CW'(DEPTH));
    assign push_entry  = '{pc: fetch_pc - 32'd4, instr: i_imem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (i_instr_ready),
        .flush     (i_b_taken),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        case (state)
            FETCH_IDLE: begin
                if (fifo_count < CW'(DEPTH)) state_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (i_imem_gnt) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (i_imem_rvalid) state_next = room_after ? FETCH_REQ : FETCH_IDLE;
            end
            FETCH_DROP: begin
                if (i_imem_rvalid) state_next = room_after ? FETCH_REQ : FETCH_IDLE;
            end
            default: state_next = FETCH_IDLE;
        endcase

        // A redirect overrides everything; a still-owed response sends us to DROP.
        if (i_b_taken) begin
            fetch_pc_next = word_align(i_b_pc);
            case (state)
                FETCH_REQ:  state_next = i_imem_gnt    ? FETCH_DROP : FETCH_REQ;
                FETCH_WAIT: state_next = i_imem_rvalid ? FETCH_REQ  : FETCH_DROP;
                FETCH_DROP: state_next = i_imem_rvalid ? FETCH_REQ  : FETCH_DROP;
                default:    state_next = FETCH_REQ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= FETCH_IDLE;
            fetch_pc     <= word_align(RESET_PC);
            misaligned_q <= 1'b0;
        end else begin
            state        <= state_next;
            fetch_pc     <= fetch_pc_next;
            misaligned_q <= i_b_taken && (i_b_pc[1:0] != 2'b00);
        end
    end

    assign o_imem_req    = (state == FETCH_REQ);
    assign o_imem_addr   = word_align(fetch_pc);
    assign o_instr_valid = !fifo_empty;
    assign o_instr       = fifo_head.instr;
    assign o_instr_pc    = fifo_head.pc;
    assign o_misaligned  = misaligned_q;
    assign o_fsm_state   = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory responder with adjustable
// latency, and a linear sequence of hand-timed checks made on falling edges.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        b_taken;
    logic [31:0] b_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        misaligned;
    logic [1:0]  fsm_state;

    int vectors = 0;
    int miscompares = 0;
    int mem_lat = 0;
    int mcyc = 0;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_b_taken     (b_taken),
        .i_b_pc        (b_pc),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .o_instr_valid (instr_valid),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .i_instr_ready (instr_ready),
        .o_misaligned  (misaligned),
        .o_fsm_state   (fsm_state)
    );

    // Memory always grants immediately; data returns mem_lat cycles after the next one.
    assign imem_gnt = imem_req;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_addr_q.delete();
                mem_due_q.delete();
            end else if (imem_req && imem_gnt) begin
                mem_addr_q.push_back(imem_addr);
                mem_due_q.push_back(mcyc + 1 + mem_lat);
            end
            @(posedge clk);
            #1;
            mcyc++;
            if (!rst_n) begin
                mem_addr_q.delete();
                mem_due_q.delete();
                imem_rvalid = 1'b0;
            end else if (mem_addr_q.size() != 0 && mem_due_q[0] <= mcyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_at(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end else begin
                imem_rvalid = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_pc"}, instr_pc, pc);
        chk({tag, "_instr"}, instr, word_at(pc));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0000_0100);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_pc"}, instr_pc, 32'h0);
        chk({tag, "_mis"}, 32'(misaligned), 32'd0);
        chk({tag, "_state"}, 32'(fsm_state), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        b_taken     = 1'b0;
        b_pc        = 32'h0;
        instr_ready = 1'b1;

        repeat (2) step();
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // Streaming at one instruction every two cycles.
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_req", 32'(imem_req), 32'd1);
            chk("t1_addr", imem_addr, 32'h100 + 32'(4 * k));
            if (k > 0) chk_head("t1_head", 32'h100 + 32'(4 * (k - 1)));
            step();
            chk("t1_req_gap", 32'(imem_req), 32'd0);
            chk("t1_valid_gap", 32'(instr_valid), 32'd0);
        end

        // Decode stalls: two entries buffer, requests stop.
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin
                chk("t2_req", 32'(imem_req), 32'd1);
                chk("t2_addr", imem_addr, 32'h110);
            end else begin
                chk("t2_req_stop", 32'(imem_req), 32'd0);
            end
            chk_head("t2_hold", 32'h10c);
        end
        instr_ready = 1'b1;
        step();
        chk_head("t2_second", 32'h110);
        chk("t2_req_idle", 32'(imem_req), 32'd0);
        step();
        chk("t2_resume_req", 32'(imem_req), 32'd1);
        chk("t2_resume_addr", imem_addr, 32'h114);
        chk("t2_drained", 32'(instr_valid), 32'd0);
        step();
        mem_lat = 3;
        step();
        chk_head("t2_next", 32'h114);
        chk("t2_addr118", imem_addr, 32'h118);

        // Redirect while waiting on a slow response.
        step();
        chk("t3_state_wait", 32'(fsm_state), 32'd2);
        b_taken = 1'b1;
        b_pc    = 32'h200;
        step();
        b_taken = 1'b0;
        mem_lat = 0;
        chk("t3_state_drop", 32'(fsm_state), 32'd3);
        chk("t3_mis", 32'(misaligned), 32'd0);
        repeat (2) begin
            step();
            chk("t3_req_off", 32'(imem_req), 32'd0);
            chk("t3_valid_off", 32'(instr_valid), 32'd0);
        end
        step();
        chk("t3_req_target", 32'(imem_req), 32'd1);
        chk("t3_addr_target", imem_addr, 32'h200);
        chk("t3_valid_off2", 32'(instr_valid), 32'd0);
        step();
        chk("t3_valid_off3", 32'(instr_valid), 32'd0);
        step();
        chk_head("t3_head", 32'h200);

        // Redirect with gnt, then with rvalid in DROP, then with rvalid in WAIT.
        b_taken = 1'b1;
        b_pc    = 32'h400;
        step();
        b_pc    = 32'h500;
        chk("t5_flushed", 32'(instr_valid), 32'd0);
        chk("t5_state_drop", 32'(fsm_state), 32'd3);
        step();
        b_taken = 1'b0;
        chk("t5_addr500", imem_addr, 32'h500);
        chk("t5_req500", 32'(imem_req), 32'd1);
        step();
        chk("t5_wait_valid", 32'(instr_valid), 32'd0);
        b_taken = 1'b1;
        b_pc    = 32'h600;
        step();
        b_taken = 1'b0;
        chk("t5_addr600", imem_addr, 32'h600);
        chk("t5_no_stale", 32'(instr_valid), 32'd0);
        step();
        chk("t5_valid_off", 32'(instr_valid), 32'd0);
        step();
        chk_head("t5_head", 32'h600);

        // Misaligned redirect while the response is arriving.
        step();
        chk("t4_valid_before", 32'(instr_valid), 32'd0);
        b_taken = 1'b1;
        b_pc    = 32'h302;
        step();
        b_taken = 1'b0;
        chk("t4_mis_pulse", 32'(misaligned), 32'd1);
        chk("t4_addr300", imem_addr, 32'h300);
        chk("t4_valid_off", 32'(instr_valid), 32'd0);
        step();
        chk("t4_mis_clear", 32'(misaligned), 32'd0);
        step();
        chk_head("t4_head", 32'h300);

        // Address wrap at the top of the space, then reset while waiting.
        b_taken = 1'b1;
        b_pc    = 32'hFFFF_FFFC;
        step();
        b_taken = 1'b0;
        chk("t6_valid_off", 32'(instr_valid), 32'd0);
        step();
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        mem_lat = 3;
        step();
        chk_head("t6_head_top", 32'hFFFF_FFFC);
        chk("t6_addr_wrap", imem_addr, 32'h0);
        step();
        chk("t6_state_wait", 32'(fsm_state), 32'd2);
        rst_n = 1'b0;
        step();
        chk_reset_outputs("t6_rst");
        rst_n   = 1'b1;
        mem_lat = 0;
        step();
        chk("t6_req_after", 32'(imem_req), 32'd1);
        chk("t6_addr_after", imem_addr, 32'h100);
        step();
        chk("t6_valid_gap", 32'(instr_valid), 32'd0);
        step();
        chk_head("t6_head_after", 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
